// File: rtl/ad9361_init_seq.sv
// ad9361_init_seq: table-driven AD9361 SPI register-write sequencer.
// Walks a synchronous command ROM (writes, us delays, end marker) while
// init_i is held high, and drives an external SPI master with req/ack.
// Ports: clk, rst (async, active-high), init_i level request,
//   done_o/busy_o/err_o status, rom_addr_o/rom_data_i command ROM,
//   spi_req_o/spi_rnw_o/spi_addr_o/spi_wdata_o/spi_ack_i/spi_rdata_i SPI master.
// Build option: define AD9361_INIT_READBACK_EN to read back and verify
//   every written register (mismatch -> err_o).
module ad9361_init_seq #(
   parameter int ROM_AW     = 6,
   parameter int CLK_PER_US = 40,
   parameter int DLY_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_i,
   output logic              done_o,
   output logic              busy_o,
   output logic              err_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [31:0]       rom_data_i,
   output logic              spi_req_o,
   output logic              spi_rnw_o,
   output logic [9:0]        spi_addr_o,
   output logic [7:0]        spi_wdata_o,
   input  logic              spi_ack_i,
   input  logic [7:0]        spi_rdata_i
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_SPI_WR,
`ifdef AD9361_INIT_READBACK_EN
      S_SPI_RD,
`endif
      S_WAIT,
      S_DONE,
      S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [ROM_AW-1:0] ptr_q, ptr_d;
   logic [DLY_W-1:0]  us_q, us_d;
   logic [PW-1:0]     pre_q, pre_d;
   logic              req_q, req_d;
   logic [9:0]        addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              ptr_last;
   logic              do_adv;
   logic              spi_done;

`ifdef AD9361_INIT_READBACK_EN
   logic              rnw_q, rnw_d;
`endif

   assign ptr_last = (ptr_q == {ROM_AW{1'b1}});
   // An ack with no request outstanding is ignored.
   assign spi_done = req_q & spi_ack_i;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      us_d    = us_q;
      pre_d   = pre_q;
      req_d   = req_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef AD9361_INIT_READBACK_EN
      rnw_d   = rnw_q;
`endif
      do_adv  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (init_i) begin
               ptr_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = init_i ? S_DECODE : S_IDLE;
         end
         S_DECODE: begin
            if (!init_i) begin
               state_d = S_IDLE;
            end else if (rom_data_i[31]) begin
               state_d = S_DONE;
            end else if (rom_data_i[30]) begin
               us_d    = rom_data_i[DLY_W-1:0];
               pre_d   = '0;
               state_d = S_WAIT;
            end else begin
               addr_d  = rom_data_i[25:16];
               wdata_d = rom_data_i[7:0];
               req_d   = 1'b1;
`ifdef AD9361_INIT_READBACK_EN
               rnw_d   = 1'b0;
`endif
               state_d = S_SPI_WR;
            end
         end
         S_SPI_WR: begin
            // An in-flight transaction always runs to its ack.
            if (spi_done) begin
               req_d = 1'b0;
               if (!init_i) begin
                  state_d = S_IDLE;
               end else begin
`ifdef AD9361_INIT_READBACK_EN
                  req_d   = 1'b1;
                  rnw_d   = 1'b1;
                  state_d = S_SPI_RD;
`else
                  do_adv  = 1'b1;
`endif
               end
            end
         end
`ifdef AD9361_INIT_READBACK_EN
         S_SPI_RD: begin
            if (spi_done) begin
               req_d = 1'b0;
               rnw_d = 1'b0;
               if (!init_i) begin
                  state_d = S_IDLE;
               end else if (spi_rdata_i != wdata_q) begin
                  state_d = S_ERR;
               end else begin
                  do_adv  = 1'b1;
               end
            end
         end
`endif
         S_WAIT: begin
            // N us takes exactly N*CLK_PER_US cycles; 0 us takes one.
            if (!init_i) begin
               state_d = S_IDLE;
            end else if (us_q == '0) begin
               do_adv = 1'b1;
            end else if (pre_q == PRE_LAST) begin
               pre_d = '0;
               us_d  = us_q - DLY_W'(1);
               if (us_q == DLY_W'(1)) begin
                  do_adv = 1'b1;
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         S_DONE, S_ERR: begin
            if (!init_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Running off the end of the table without END is an error.
      if (do_adv) begin
         if (ptr_last) begin
            state_d = S_ERR;
         end else begin
            ptr_d   = ptr_q + ROM_AW'(1);
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         us_q    <= '0;
         pre_q   <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef AD9361_INIT_READBACK_EN
         rnw_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         us_q    <= us_d;
         pre_q   <= pre_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef AD9361_INIT_READBACK_EN
         rnw_q   <= rnw_d;
`endif
      end
   end

   assign done_o      = (state_q == S_DONE);
   assign err_o       = (state_q == S_ERR);
   assign busy_o      = !((state_q == S_IDLE) ||
                          (state_q == S_DONE) ||
                          (state_q == S_ERR));
   assign rom_addr_o  = ptr_q;
   assign spi_req_o   = req_q;
   assign spi_addr_o  = addr_q;
   assign spi_wdata_o = wdata_q;

   // Command fields not used by every build are folded here.
   logic unused_in;
`ifdef AD9361_INIT_READBACK_EN
   assign spi_rnw_o = rnw_q;
   assign unused_in = ^rom_data_i;
`else
   assign spi_rnw_o = 1'b0;
   assign unused_in = ^{rom_data_i, spi_rdata_i};
`endif

endmodule

// File: tb/tb_ad9361_init_seq.sv
// tb_ad9361_init_seq: self-checking bench for ad9361_init_seq.
// Small ROM (4 entries), CLK_PER_US=4, behavioural SPI master and ROM.
module tb_ad9361_init_seq;

   localparam int AW  = 2;
   localparam int CPU = 4;
   localparam int DW  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_i = 1'b0;
   logic          done_o, busy_o, err_o;
   logic [AW-1:0] rom_addr_o;
   logic [31:0]   rom_data_i = '0;
   logic          spi_req_o, spi_rnw_o;
   logic [9:0]    spi_addr_o;
   logic [7:0]    spi_wdata_o;
   logic          spi_ack_i = 1'b0;
   logic [7:0]    spi_rdata_i = '0;

   int n_tests = 0;
   int n_fail  = 0;

   ad9361_init_seq #(
      .ROM_AW(AW), .CLK_PER_US(CPU), .DLY_W(DW)
   ) dut (
      .clk(clk), .rst(rst), .init_i(init_i),
      .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
      .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
      .spi_req_o(spi_req_o), .spi_rnw_o(spi_rnw_o),
      .spi_addr_o(spi_addr_o), .spi_wdata_o(spi_wdata_o),
      .spi_ack_i(spi_ack_i), .spi_rdata_i(spi_rdata_i)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, one cycle latency.
   logic [31:0] rom [4];
   always @(posedge clk) rom_data_i <= rom[rom_addr_o];

   // SPI master: ack ack_dly cycles after req is seen, log each transaction.
   int          ack_dly = 4;
   int          acnt = 0;
   logic [7:0]  regs [1024];
   logic [7:0]  rb_xor = '0;
   logic [18:0] log_q [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_ack_i <= 1'b0;
         acnt      <= 0;
      end else begin
         spi_ack_i <= 1'b0;
         if (!spi_req_o || spi_ack_i) begin
            acnt <= 0;
         end else if (acnt >= ack_dly - 1) begin
            spi_ack_i   <= 1'b1;
            spi_rdata_i <= regs[spi_addr_o] ^ rb_xor;
            if (!spi_rnw_o) regs[spi_addr_o] <= spi_wdata_o;
            log_q.push_back({spi_rnw_o, spi_addr_o, spi_wdata_o});
            acnt <= 0;
         end else begin
            acnt <= acnt + 1;
         end
      end
   end

   function automatic logic [31:0] c_wr(input logic [9:0] a,
                                        input logic [7:0] d);
      return {6'b000000, a, 8'h00, d};
   endfunction

   function automatic logic [31:0] c_wait(input logic [15:0] n);
      return {2'b01, 14'h0000, n};
   endfunction

   localparam logic [31:0] C_END = 32'h8000_0000;

   // Reference model: walk the table by its rules.
   logic [18:0] exp_q [$];
   bit          exp_done;

   task automatic model();
      logic [31:0] w;
      exp_q.delete();
      exp_done = 1'b0;
      for (int p = 0; p < 4; p++) begin
         w = rom[p];
         if (w[31]) begin
            exp_done = 1'b1;
            break;
         end
         if (!w[30]) begin
            exp_q.push_back({1'b0, w[25:16], w[7:0]});
`ifdef AD9361_INIT_READBACK_EN
            exp_q.push_back({1'b1, w[25:16], w[7:0]});
`endif
         end
      end
   endtask

   task automatic load(input logic [31:0] a, b, c, d);
      rom[0] = a;
      rom[1] = b;
      rom[2] = c;
      rom[3] = d;
   endtask

   task automatic do_reset();
      init_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      log_q.delete();
   endtask

   task automatic run_init(input int budget, output int cyc);
      init_i = 1'b1;
      cyc = 0;
      while (!(done_o || err_o) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_req(input int budget, output bit got);
      int n;
      n = 0;
      while (!spi_req_o && n < budget) begin
         @(negedge clk);
         n++;
      end
      got = spi_req_o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      init_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({done_o, busy_o, err_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_status got %b want 000",
                  {done_o, busy_o, err_o});
      end
      n_tests++;
      if ({spi_req_o, spi_rnw_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_req got %b want 00", {spi_req_o, spi_rnw_o});
      end
      n_tests++;
      if ({rom_addr_o, spi_addr_o, spi_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_bus got %h %h %h want 0",
                  rom_addr_o, spi_addr_o, spi_wdata_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_two_writes();
      int          cyc;
      logic [18:0] wr [$];
      load(c_wr(10'h3DF, 8'h01), c_wr(10'h2A6, 8'h0E), C_END, 32'h0);
      ack_dly = 4;
      rb_xor = '0;
      do_reset();
      run_init(500, cyc);
      foreach (log_q[i]) if (!log_q[i][18]) wr.push_back(log_q[i]);
      n_tests++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL two_wr_status got d%b b%b e%b want d1 b0 e0",
                  done_o, busy_o, err_o);
      end
      n_tests++;
      if (wr.size() != 2) begin
         n_fail++;
         $display("FAIL two_wr_count got %0d want 2", wr.size());
      end else begin
         n_tests++;
         if (wr[0] !== {1'b0, 10'h3DF, 8'h01}) begin
            n_fail++;
            $display("FAIL two_wr_tx0 got %h want %h", wr[0],
                     {1'b0, 10'h3DF, 8'h01});
         end
         n_tests++;
         if (wr[1] !== {1'b0, 10'h2A6, 8'h0E}) begin
            n_fail++;
            $display("FAIL two_wr_tx1 got %h want %h", wr[1],
                     {1'b0, 10'h2A6, 8'h0E});
         end
      end
      init_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL two_wr_release got d%b b%b want d0 b0",
                  done_o, busy_o);
      end
   endtask

   task automatic test_wait();
      int cyc, want;
      int dly [2] = '{3, 0};
      for (int k = 0; k < 2; k++) begin
         load(c_wait(16'(dly[k])), C_END, 32'h0, 32'h0);
         do_reset();
         run_init(200, cyc);
         // IDLE/FETCH/DECODE before, FETCH/DECODE after the wait.
         want = 5 + dly[k] * CPU;
         n_tests++;
         if (done_o !== 1'b1 || cyc < want - 1 || cyc > want + 1) begin
            n_fail++;
            $display("FAIL wait%0d_timing got done=%b after %0d want %0d+-1",
                     dly[k], done_o, cyc, want);
         end
         init_i = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_abort_spi();
      bit got, held, done_bad;
      int n;
      load(c_wr(10'h123, 8'h55), C_END, 32'h0, 32'h0);
      ack_dly = 10;
      do_reset();
      init_i = 1'b1;
      wait_req(20, got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL abort_req got 0 want 1");
      end
      repeat (2) @(negedge clk);
      init_i = 1'b0;
      held = 1'b1;
      done_bad = 1'b0;
      n = 0;
      while (!spi_ack_i && n < 30) begin
         if (!spi_req_o) held = 1'b0;
         done_bad |= done_o;
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (!held || n >= 30) begin
         n_fail++;
         $display("FAIL abort_hold got held=%b acked=%b want 1 1",
                  held, n < 30);
      end
      repeat (3) begin
         @(negedge clk);
         done_bad |= done_o;
      end
      n_tests++;
      if (busy_o !== 1'b0 || spi_req_o !== 1'b0 || done_bad) begin
         n_fail++;
         $display("FAIL abort_idle got b%b r%b done_seen%b want 0 0 0",
                  busy_o, spi_req_o, done_bad);
      end
      ack_dly = 4;
   endtask

   task automatic test_no_end();
      int cyc;
      load(c_wr(10'h001, 8'hA1), c_wr(10'h002, 8'hA2),
           c_wr(10'h003, 8'hA3), c_wr(10'h004, 8'hA4));
      ack_dly = 2;
      do_reset();
      run_init(500, cyc);
      model();
      n_tests++;
      if (err_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL no_end_status got e%b d%b want e1 d0", err_o, done_o);
      end
      n_tests++;
      if (log_q.size() != exp_q.size() || log_q.size() < 4) begin
         n_fail++;
         $display("FAIL no_end_count got %0d want %0d",
                  log_q.size(), exp_q.size());
      end else begin
         n_tests++;
         if (log_q[log_q.size()-1][7:0] !== 8'hA4) begin
            n_fail++;
            $display("FAIL no_end_last got %h want a4",
                     log_q[log_q.size()-1][7:0]);
         end
      end
      init_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL no_end_release got e%b want e0", err_o);
      end
   endtask

   task automatic test_rst_mid();
      bit got;
      int cyc;
      load(c_wr(10'h3DF, 8'h01), c_wr(10'h2A6, 8'h0E), C_END, 32'h0);
      ack_dly = 8;
      do_reset();
      init_i = 1'b1;
      wait_req(20, got);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (spi_req_o !== 1'b0 || busy_o !== 1'b0 ||
          {rom_addr_o, spi_addr_o, spi_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async got r%b b%b a%h want 0 0 0",
                  spi_req_o, busy_o, spi_addr_o);
      end
      @(negedge clk);
      rst = 1'b0;
      log_q.delete();
      run_init(500, cyc);
      model();
      n_tests++;
      if (done_o !== 1'b1 || log_q.size() != exp_q.size() ||
          (log_q.size() > 0 && log_q[0] !== exp_q[0])) begin
         n_fail++;
         $display("FAIL rst_mid_rerun got d%b n%0d want d1 n%0d from %h",
                  done_o, log_q.size(), exp_q.size(), exp_q[0]);
      end
      init_i = 1'b0;
      @(negedge clk);
      ack_dly = 4;
   endtask

   task automatic test_random();
      int          cyc;
      int          r;
      logic [31:0] w;
      rb_xor = '0;
      for (int it = 0; it < 25; it++) begin
         for (int p = 0; p < 4; p++) begin
            r = $urandom_range(0, 9);
            w = $urandom;
            if (r < 2) w[31] = 1'b1;
            else if (r < 4) w = {2'b01, w[29:16], 16'($urandom_range(0, 3))};
            else w[31:30] = 2'b00;
            rom[p] = w;
         end
         ack_dly = $urandom_range(1, 5);
         do_reset();
         run_init(3000, cyc);
         model();
         n_tests++;
         if (cyc >= 3000 || done_o !== exp_done || err_o !== !exp_done) begin
            n_fail++;
            $display("FAIL rand%0d_end got d%b e%b cyc%0d want d%b",
                     it, done_o, err_o, cyc, exp_done);
         end
         n_tests++;
         if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand%0d_count got %0d want %0d",
                     it, log_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               n_tests++;
               if (log_q[i] !== exp_q[i]) begin
                  n_fail++;
                  $display("FAIL rand%0d_tx%0d got %h want %h",
                           it, i, log_q[i], exp_q[i]);
               end
            end
         end
         init_i = 1'b0;
         @(negedge clk);
      end
   endtask

`ifdef AD9361_INIT_READBACK_EN
   task automatic test_readback();
      int cyc;
      load(c_wr(10'h2A6, 8'h0E), c_wr(10'h100, 8'h33), C_END, 32'h0);
      ack_dly = 3;
      rb_xor = 8'h00;
      do_reset();
      run_init(500, cyc);
      n_tests++;
      if (done_o !== 1'b1 || log_q.size() != 4 ||
          log_q[1] !== {1'b1, 10'h2A6, 8'h0E}) begin
         n_fail++;
         $display("FAIL rb_match got d%b n%0d want d1 n4", done_o,
                  log_q.size());
      end
      init_i = 1'b0;
      @(negedge clk);
      rb_xor = 8'h01;
      do_reset();
      run_init(500, cyc);
      n_tests++;
      if (err_o !== 1'b1 || done_o !== 1'b0 || log_q.size() != 2) begin
         n_fail++;
         $display("FAIL rb_mismatch got e%b d%b n%0d want e1 d0 n2",
                  err_o, done_o, log_q.size());
      end
      init_i = 1'b0;
      rb_xor = 8'h00;
      @(negedge clk);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_two_writes();
      test_wait();
      test_abort_spi();
      test_no_end();
      test_rst_mid();
`ifdef AD9361_INIT_READBACK_EN
      test_readback();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
